// File: rtl/edxel_axil_regs_if.sv
// AXI4-Lite S00_AXI link bundle between the block-design/PS master and edxel_axil_regs.
// Clock and reset stay outside the bundle.
interface edxel_axil_regs_if #(
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int C_S_AXI_DATA_WIDTH = 32
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]                      S_AXI_AWPROT;
  logic                            S_AXI_AWVALID;
  logic                            S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                            S_AXI_WVALID;
  logic                            S_AXI_WREADY;
  logic [1:0]                      S_AXI_BRESP;
  logic                            S_AXI_BVALID;
  logic                            S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]                      S_AXI_ARPROT;
  logic                            S_AXI_ARVALID;
  logic                            S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]                      S_AXI_RRESP;
  logic                            S_AXI_RVALID;
  logic                            S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/edxel_axil_regs.sv
// AXI4-Lite responder with four 32-bit EdXel control registers on reg_out; EDXEL_AXIL_SLVERR_EN adds SLVERR for addr[5:4]!=0.
// B/R valid 1 cycle after the final handshake; one write and one read in flight, each held until BREADY/RREADY.
module edxel_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  edxel_axil_regs_if.slave                  s_axi,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0]   reg_out
);

  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [DW-1:0]   data;
    logic [DW/8-1:0] strb;
  } wr_req_t;

  logic          aw_held;
  logic          w_held;
  wr_req_t       wr_q;
  wr_req_t       wr_cur;
  logic [DW-1:0] regs [4];

  logic          bvalid_q;
  logic [1:0]    bresp_q;
  logic          rvalid_q;
  logic [1:0]    rresp_q;
  logic [DW-1:0] rdata_q;

  logic aw_rdy, w_rdy, ar_rdy;
  logic aw_hs, w_hs, ar_hs;
  logic commit;
  logic wr_err, rd_err;
  logic unused_bits;

  assign aw_rdy = !aw_held && !bvalid_q;
  assign w_rdy  = !w_held && !bvalid_q;
  assign ar_rdy = !rvalid_q;

  assign aw_hs = s_axi.S_AXI_AWVALID && aw_rdy;
  assign w_hs  = s_axi.S_AXI_WVALID && w_rdy;
  assign ar_hs = s_axi.S_AXI_ARVALID && ar_rdy;

  // Merge live handshakes with held slots so commit can use whichever half arrived now.
  always_comb begin
    wr_cur = wr_q;
    if (aw_hs) wr_cur.addr = s_axi.S_AXI_AWADDR;
    if (w_hs) begin
      wr_cur.data = s_axi.S_AXI_WDATA;
      wr_cur.strb = s_axi.S_AXI_WSTRB;
    end
  end

  assign commit = (aw_hs || aw_held) && (w_hs || w_held);

`ifdef EDXEL_AXIL_SLVERR_EN
  assign wr_err = |wr_cur.addr[AW-1:4];
  assign rd_err = |s_axi.S_AXI_ARADDR[AW-1:4];
`else
  assign wr_err = 1'b0;
  assign rd_err = 1'b0;
`endif

  assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         wr_cur.addr[1:0], wr_cur.addr[AW-1:4],
                         s_axi.S_AXI_ARADDR[1:0], s_axi.S_AXI_ARADDR[AW-1:4]};

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      wr_q    <= '0;
    end else begin
      wr_q <= wr_cur;
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end else begin
        if (aw_hs) aw_held <= 1'b1;
        if (w_hs)  w_held  <= 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (commit && !wr_err) begin
      for (int k = 0; k < DW/8; k++) begin
        if (wr_cur.strb[k]) regs[wr_cur.addr[3:2]][8*k +: 8] <= wr_cur.data[8*k +: 8];
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else if (commit) begin
      bvalid_q <= 1'b1;
      bresp_q  <= wr_err ? RESP_SLVERR : RESP_OKAY;
    end else if (s_axi.S_AXI_BREADY) begin
      bvalid_q <= 1'b0;
    end
  end

  // Read samples regs before this edge's write lands, so a same-edge read sees the old value.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rresp_q  <= rd_err ? RESP_SLVERR : RESP_OKAY;
      rdata_q  <= rd_err ? '0 : regs[s_axi.S_AXI_ARADDR[3:2]];
    end else if (s_axi.S_AXI_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

  assign s_axi.S_AXI_AWREADY = aw_rdy;
  assign s_axi.S_AXI_WREADY  = w_rdy;
  assign s_axi.S_AXI_ARREADY = ar_rdy;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;

  assign reg_out = {regs[3], regs[2], regs[1], regs[0]};

endmodule

// File: tb/tb_edxel_axil_regs.sv
// Directed bench for edxel_axil_regs: reset state, full/partial writes, AW/W skew, B backpressure,
// out-of-window access (both builds of EDXEL_AXIL_SLVERR_EN), same-edge read/write and mid-write reset.
module tb_edxel_axil_regs;

  logic         tb_ACLK = 1'b0;
  logic         tb_ARESETN;
  logic [127:0] reg_out;
  int           total = 0;
  int           bad = 0;
  logic [1:0]   resp;
  logic [31:0]  rd;
  logic [31:0]  wv [4];

  edxel_axil_regs_if #(.C_S_AXI_ADDR_WIDTH(6), .C_S_AXI_DATA_WIDTH(32)) bus ();

  edxel_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6)) dut (
    .ACLK    (tb_ACLK),
    .ARESETN (tb_ARESETN),
    .s_axi   (bus),
    .reg_out (reg_out)
  );

  always #5 tb_ACLK = ~tb_ACLK;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge tb_ACLK);
    #1;
  endtask

  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] r);
    bit aw_done = 1'b0;
    bit w_done  = 1'b0;
    int n = 0;
    bus.S_AXI_AWADDR  = addr;
    bus.S_AXI_WDATA   = data;
    bus.S_AXI_WSTRB   = strb;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b1;
    while (!(aw_done && w_done) && n < 50) begin
      if (bus.S_AXI_AWVALID && bus.S_AXI_AWREADY) aw_done = 1'b1;
      if (bus.S_AXI_WVALID && bus.S_AXI_WREADY) w_done = 1'b1;
      tick();
      n++;
      if (aw_done) bus.S_AXI_AWVALID = 1'b0;
      if (w_done)  bus.S_AXI_WVALID  = 1'b0;
    end
    chk1("wr_handshake_done", aw_done && w_done, 1'b1);
    chk1("wr_bvalid_latency", bus.S_AXI_BVALID, 1'b1);
    r = bus.S_AXI_BRESP;
    bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_BREADY = 1'b0;
    chk1("wr_bvalid_clear", bus.S_AXI_BVALID, 1'b0);
  endtask

  task automatic axi_read(input logic [5:0] addr, output logic [31:0] d, output logic [1:0] r);
    bit ar_done = 1'b0;
    int n = 0;
    bus.S_AXI_ARADDR  = addr;
    bus.S_AXI_ARVALID = 1'b1;
    while (!ar_done && n < 50) begin
      if (bus.S_AXI_ARREADY) ar_done = 1'b1;
      tick();
      n++;
    end
    bus.S_AXI_ARVALID = 1'b0;
    chk1("rd_handshake_done", ar_done, 1'b1);
    chk1("rd_rvalid_latency", bus.S_AXI_RVALID, 1'b1);
    d = bus.S_AXI_RDATA;
    r = bus.S_AXI_RRESP;
    bus.S_AXI_RREADY = 1'b1;
    tick();
    bus.S_AXI_RREADY = 1'b0;
    chk1("rd_rvalid_clear", bus.S_AXI_RVALID, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    wv[0] = 32'h0101FFFF;
    wv[1] = 32'hABCD0001;
    wv[2] = 32'hDEAD0011;
    wv[3] = 32'hBEEF0011;

    tb_ARESETN        = 1'b0;
    bus.S_AXI_AWADDR  = '0;
    bus.S_AXI_AWPROT  = '0;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA   = '0;
    bus.S_AXI_WSTRB   = '0;
    bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_BREADY  = 1'b0;
    bus.S_AXI_ARADDR  = '0;
    bus.S_AXI_ARPROT  = '0;
    bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY  = 1'b0;

    // Reset state
    #12;
    chk1("rst_awready", bus.S_AXI_AWREADY, 1'b1);
    chk1("rst_wready", bus.S_AXI_WREADY, 1'b1);
    chk1("rst_arready", bus.S_AXI_ARREADY, 1'b1);
    chk1("rst_bvalid", bus.S_AXI_BVALID, 1'b0);
    chk1("rst_rvalid", bus.S_AXI_RVALID, 1'b0);
    chk2("rst_bresp", bus.S_AXI_BRESP, 2'b00);
    chk2("rst_rresp", bus.S_AXI_RRESP, 2'b00);
    chk32("rst_rdata", bus.S_AXI_RDATA, 32'h0);
    chk128("rst_reg_out", reg_out, 128'h0);
    @(negedge tb_ACLK);
    tb_ARESETN = 1'b1;
    tick();

    // Full-word writes then read-back
    for (int i = 0; i < 4; i++) begin
      axi_write(6'(i * 4), wv[i], 4'hF, resp);
      chk2("wr_full_bresp", resp, 2'b00);
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(6'(i * 4), rd, resp);
      chk32("rd_full_data", rd, wv[i]);
      chk2("rd_full_rresp", resp, 2'b00);
    end
    chk128("reg_out_full", reg_out, 128'hBEEF0011_DEAD0011_ABCD0001_0101FFFF);

    // Byte strobes: low two bytes only
    axi_write(6'h4, 32'h12345678, 4'b0011, resp);
    chk2("wr_strb_bresp", resp, 2'b00);
    axi_read(6'h4, rd, resp);
    chk32("rd_strb_data", rd, 32'hABCD5678);

    // AW leads W by 3 cycles
    bus.S_AXI_AWADDR  = 6'h8;
    bus.S_AXI_WDATA   = 32'h11112222;
    bus.S_AXI_WSTRB   = 4'hF;
    bus.S_AXI_AWVALID = 1'b1;
    tick();
    bus.S_AXI_AWVALID = 1'b0;
    chk1("awfirst_awready_held", bus.S_AXI_AWREADY, 1'b0);
    chk1("awfirst_wready_open", bus.S_AXI_WREADY, 1'b1);
    tick();
    chk1("awfirst_no_bvalid_1", bus.S_AXI_BVALID, 1'b0);
    tick();
    chk1("awfirst_no_bvalid_2", bus.S_AXI_BVALID, 1'b0);
    bus.S_AXI_WVALID = 1'b1;
    tick();
    bus.S_AXI_WVALID = 1'b0;
    chk1("awfirst_bvalid_latency", bus.S_AXI_BVALID, 1'b1);
    chk32("awfirst_reg2", reg_out[95:64], 32'h11112222);
    bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_BREADY = 1'b0;
    chk1("awfirst_bvalid_clear", bus.S_AXI_BVALID, 1'b0);

    // W leads AW by 3 cycles
    bus.S_AXI_AWADDR = 6'hC;
    bus.S_AXI_WDATA  = 32'h33334444;
    bus.S_AXI_WVALID = 1'b1;
    tick();
    bus.S_AXI_WVALID = 1'b0;
    chk1("wfirst_wready_held", bus.S_AXI_WREADY, 1'b0);
    chk1("wfirst_awready_open", bus.S_AXI_AWREADY, 1'b1);
    tick();
    tick();
    chk1("wfirst_no_bvalid", bus.S_AXI_BVALID, 1'b0);
    bus.S_AXI_AWVALID = 1'b1;
    tick();
    bus.S_AXI_AWVALID = 1'b0;
    chk1("wfirst_bvalid_latency", bus.S_AXI_BVALID, 1'b1);
    chk32("wfirst_reg3", reg_out[127:96], 32'h33334444);
    bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_BREADY = 1'b0;

    // BREADY held low for 5 cycles with a concurrent read of 0x8
    bus.S_AXI_AWADDR  = 6'h0;
    bus.S_AXI_WDATA   = 32'hCAFE0000;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b1;
    tick();
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_ARADDR  = 6'h8;
    bus.S_AXI_ARVALID = 1'b1;
    bus.S_AXI_RREADY  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk1("bstall_bvalid", bus.S_AXI_BVALID, 1'b1);
      chk2("bstall_bresp", bus.S_AXI_BRESP, 2'b00);
      chk1("bstall_awready", bus.S_AXI_AWREADY, 1'b0);
      chk1("bstall_wready", bus.S_AXI_WREADY, 1'b0);
      tick();
      if (i == 0) begin
        bus.S_AXI_ARVALID = 1'b0;
        chk1("bstall_rvalid", bus.S_AXI_RVALID, 1'b1);
        chk32("bstall_rdata", bus.S_AXI_RDATA, 32'h11112222);
      end
      if (i == 1) chk1("bstall_rvalid_clear", bus.S_AXI_RVALID, 1'b0);
    end
    bus.S_AXI_RREADY = 1'b0;
    chk1("bstall_bvalid_end", bus.S_AXI_BVALID, 1'b1);
    bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_BREADY = 1'b0;
    chk1("bstall_bvalid_clear", bus.S_AXI_BVALID, 1'b0);
    chk32("bstall_reg0", reg_out[31:0], 32'hCAFE0000);

    // Out-of-window access at 0x20
    axi_write(6'h20, 32'h5A5A5A5A, 4'hF, resp);
`ifdef EDXEL_AXIL_SLVERR_EN
    chk2("oow_bresp", resp, 2'b10);
    chk32("oow_reg0_kept", reg_out[31:0], 32'hCAFE0000);
    axi_read(6'h20, rd, resp);
    chk2("oow_rresp", resp, 2'b10);
    chk32("oow_rdata", rd, 32'h0);
`else
    chk2("oow_bresp", resp, 2'b00);
    chk32("oow_reg0_alias", reg_out[31:0], 32'h5A5A5A5A);
    axi_read(6'h20, rd, resp);
    chk2("oow_rresp", resp, 2'b00);
    chk32("oow_rdata", rd, 32'h5A5A5A5A);
`endif

    // Same-edge write and read of reg2: read returns the pre-write value
    bus.S_AXI_AWADDR  = 6'h8;
    bus.S_AXI_WDATA   = 32'h77778888;
    bus.S_AXI_ARADDR  = 6'h8;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b1;
    bus.S_AXI_ARVALID = 1'b1;
    tick();
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_ARVALID = 1'b0;
    chk1("same_edge_bvalid", bus.S_AXI_BVALID, 1'b1);
    chk1("same_edge_rvalid", bus.S_AXI_RVALID, 1'b1);
    chk32("same_edge_rdata_old", bus.S_AXI_RDATA, 32'h11112222);
    chk32("same_edge_reg2_new", reg_out[95:64], 32'h77778888);
    bus.S_AXI_BREADY = 1'b1;
    bus.S_AXI_RREADY = 1'b1;
    tick();
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_RREADY = 1'b0;

    // Reset between an accepted AW and its W
    bus.S_AXI_AWADDR  = 6'h0;
    bus.S_AXI_AWVALID = 1'b1;
    tick();
    bus.S_AXI_AWVALID = 1'b0;
    chk1("midrst_aw_held", bus.S_AXI_AWREADY, 1'b0);
    #2;
    tb_ARESETN = 1'b0;
    #1;
    chk1("midrst_awready", bus.S_AXI_AWREADY, 1'b1);
    chk1("midrst_wready", bus.S_AXI_WREADY, 1'b1);
    chk1("midrst_bvalid", bus.S_AXI_BVALID, 1'b0);
    chk128("midrst_reg_out", reg_out, 128'h0);
    @(negedge tb_ACLK);
    tb_ARESETN = 1'b1;
    tick();
    bus.S_AXI_WDATA  = 32'h600DCAFE;
    bus.S_AXI_WSTRB  = 4'hF;
    bus.S_AXI_WVALID = 1'b1;
    tick();
    bus.S_AXI_WVALID = 1'b0;
    chk1("postrst_no_stale_commit", bus.S_AXI_BVALID, 1'b0);
    chk128("postrst_reg_out_idle", reg_out, 128'h0);
    bus.S_AXI_AWADDR  = 6'h4;
    bus.S_AXI_AWVALID = 1'b1;
    tick();
    bus.S_AXI_AWVALID = 1'b0;
    chk1("postrst_bvalid", bus.S_AXI_BVALID, 1'b1);
    chk2("postrst_bresp", bus.S_AXI_BRESP, 2'b00);
    chk128("postrst_reg_out", reg_out, 128'h00000000_00000000_600DCAFE_00000000);
    bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_BREADY = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/edxel_axil_regs.md
# edxel_axil_regs

AXI4-Lite responder (slave) providing four 32-bit read/write control registers for the EdXel datapath. It is the far end of the S00_AXI link driven by the block-design AXI4-Lite master in simulation and by the PS interconnect in hardware. Register contents are exported as a flat bus to downstream EdXel logic. All bus responses are OKAY except for out-of-window accesses, which return SLVERR when the optional error feature below is compiled in.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 6, byte-address width. The full 64-byte window has four registers implemented at offsets 0x0, 0x4, 0x8 and 0xC.
- ACLK  in  1  sole clock; all state changes on its rising edge.
- ARESETN  in  1  reset, asynchronous assert, active-low.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address. S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID in 1 / S_AXI_AWREADY out 1  write-address handshake.
- S_AXI_WDATA  in  32  write data. S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID in 1 / S_AXI_WREADY out 1  write-data handshake.
- S_AXI_BRESP  out  2  write response. S_AXI_BVALID out 1 / S_AXI_BREADY in 1  write-response handshake.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address. S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID in 1 / S_AXI_ARREADY out 1  read-address handshake.
- S_AXI_RDATA  out  32  read data. S_AXI_RRESP  out  2  read response. S_AXI_RVALID out 1 / S_AXI_RREADY in 1  read-data handshake.
- reg_out  out  128  register contents: reg0 in [31:0] through reg3 in [127:96].

## Operation
- Write path has independent AW and W holding slots, `aw_held` and `w_held`.
  - AWREADY = !aw_held & !BVALID; WREADY = !w_held & !BVALID. Both are combinational from state only and never depend on VALID.
  - The AW handshake latches the address. The W handshake latches data and strobes.
- Commit occurs on the edge where the second of the AW/W pair completes, or where both complete together.
  - On commit, register[addr[3:2]] byte k is updated only if WSTRB[k] is set.
  - On commit, the held flags clear and BVALID is set.
- BVALID, with BRESP, is held until BREADY. It clears on the BVALID&BREADY edge.
  - No new AW or W is accepted while BVALID is high, so at most one write is outstanding.
- Read path: ARREADY = !RVALID.
  - On the AR handshake edge, RDATA and RRESP are captured and RVALID is set.
  - RVALID and RDATA are held stable until RREADY; RVALID clears on the handshake edge.
- Address decode uses bits [3:2]. Bits [1:0] are ignored.
- Simultaneous write commit and read of the same register on one edge: RDATA returns the pre-write value.
- Reads and writes proceed fully concurrently. Neither path stalls the other.

## Timing
- Reset values while ARESETN=0: all registers 0, aw_held=w_held=0, AWREADY=WREADY=ARREADY=1, BVALID=RVALID=0, BRESP=RRESP=2'b00, RDATA=0, reg_out=0.
- Reset asserted mid-transaction aborts the transaction immediately. Any partially held AW or W is discarded.
- Write latency: BVALID goes high in the cycle after the final AW/W handshake edge. reg_out reflects new data in that same cycle.
- Read latency: RVALID goes high in the cycle after the AR handshake.
- Back-to-back throughput, with BREADY/RREADY held high: one write per 2 cycles and one read per 2 cycles.

## Configuration
- EDXEL_AXIL_SLVERR_EN defined:
  - Any access with address bits [C_S_AXI_ADDR_WIDTH-1:4] non-zero is out-of-window.
  - An out-of-window write completes the handshake, returns BRESP=2'b10 (SLVERR) and modifies no register.
  - An out-of-window read returns RRESP=2'b10 with RDATA=0.
- EDXEL_AXIL_SLVERR_EN undefined: upper address bits are ignored, out-of-window accesses alias onto reg0–reg3, and responses are always OKAY.

## Test plan
- After reset, write 0x0101FFFF, 0xABCD0001, 0xDEAD0011 and 0xBEEF0011 to 0x0, 0x4, 0x8 and 0xC. Read each back: data matches, BRESP and RRESP are 2'b00, and reg_out = 0xBEEF0011_DEAD0011_ABCD0001_0101FFFF.
- Write 0x12345678 with WSTRB=4'b0011 over reg1=0xABCD0001: read returns 0xABCD5678.
- Present AWVALID 3 cycles before WVALID, then repeat with W first: both commit correctly and BVALID rises exactly 1 cycle after the second handshake.
- Hold BREADY low for 5 cycles after a write: BVALID and BRESP stay stable, AWREADY and WREADY stay 0, and a concurrent read of 0x8 completes normally.
- Write 0x5A5A5A5A to 0x20:
  - With EDXEL_AXIL_SLVERR_EN: BRESP=2'b10, reg0 unchanged, and a read of 0x20 returns RRESP=2'b10 with RDATA=0.
  - Without the macro: reg0 becomes 0x5A5A5A5A with OKAY.
- Assert ARESETN low between an accepted AW and its W: outputs return to reset values asynchronously. After release, a fresh write to 0x4 commits cleanly with no stale address used.
